imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_pkg.sv | 26 ++
 rtl/imm_encoder_if.sv | 32 +++
 rtl/imm_pack.sv | 73 +++++++
 rtl/imm_encoder.sv | 92 +++++++++
 tb/tb_imm_encoder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_encoder_pkg : RV32I immediate format codes, field widths, format masks
// Rev 1.0
// ---------------------------------------------------------------------------
package imm_encoder_pkg;

    localparam int VAL_W       = 32;
    localparam int IMM_FIELD_W = 25;
    localparam int ERR_CNT_W   = 16;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_e;

    // Bit positions of instr[31:7] that carry immediate bits, per format
    localparam logic [IMM_FIELD_W-1:0] MASK_I  = 25'h1FFE000;
    localparam logic [IMM_FIELD_W-1:0] MASK_SB = 25'h1FC001F;
    localparam logic [IMM_FIELD_W-1:0] MASK_JU = 25'h1FFFFE0;

endpackage
`default_nettype wire

// File: rtl/imm_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_encoder_if : valid/ready input and output channels plus error counter
// Rev 1.0
// ---------------------------------------------------------------------------
interface imm_encoder_if;
    import imm_encoder_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [VAL_W-1:0]       ImmExt;
    logic [2:0]             ImmSel;
    logic                   out_valid;
    logic                   out_ready;
    logic [IMM_FIELD_W-1:0] imm;
    logic [IMM_FIELD_W-1:0] imm_mask;
    logic                   imm_err;
    logic [ERR_CNT_W-1:0]   err_cnt;
    logic                   err_clr;

    modport master (
        output in_valid, ImmExt, ImmSel, out_ready, err_clr,
        input  in_ready, out_valid, imm, imm_mask, imm_err, err_cnt
    );

    modport slave (
        input  in_valid, ImmExt, ImmSel, out_ready, err_clr,
        output in_ready, out_valid, imm, imm_mask, imm_err, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_pack : combinational scatter of a value into instr[31:7] + range check
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_pack
    import imm_encoder_pkg::*;
(
    input  wire logic [VAL_W-1:0]       val,
    input  wire logic [2:0]             sel,
    output logic      [IMM_FIELD_W-1:0] imm,
    output logic      [IMM_FIELD_W-1:0] imm_mask,
    output logic                        imm_err
);

    logic                   w_hi11_same;
    logic                   w_hi12_same;
    logic                   w_hi20_same;
    logic [IMM_FIELD_W-1:0] w_field;
    logic                   w_ok;

    // Sign-extension checks: the bits above the top encoded bit must replicate it
    assign w_hi11_same = (val[31:11] == '0) || (val[31:11] == '1);
    assign w_hi12_same = (val[31:12] == '0) || (val[31:12] == '1);
    assign w_hi20_same = (val[31:20] == '0) || (val[31:20] == '1);

    always_comb begin
        w_field  = '0;
        imm_mask = '0;
        w_ok     = 1'b0;
        case (sel)
            IMM_I: begin
                w_field[24:13] = val[11:0];
                imm_mask       = MASK_I;
                w_ok           = w_hi11_same;
            end
            IMM_S: begin
                w_field[24:18] = val[11:5];
                w_field[4:0]   = val[4:0];
                imm_mask       = MASK_SB;
                w_ok           = w_hi11_same;
            end
            IMM_B: begin
                w_field[24]    = val[12];
                w_field[23:18] = val[10:5];
                w_field[4:1]   = val[4:1];
                w_field[0]     = val[11];
                imm_mask       = MASK_SB;
                w_ok           = w_hi12_same && !val[0];
            end
            IMM_J: begin
                w_field[24]    = val[20];
                w_field[23:14] = val[10:1];
                w_field[13]    = val[11];
                w_field[12:5]  = val[19:12];
                imm_mask       = MASK_JU;
                w_ok           = w_hi20_same && !val[0];
            end
            IMM_U: begin
                w_field[24:5]  = val[31:12];
                imm_mask       = MASK_JU;
                w_ok           = (val[11:0] == '0);
            end
            default: begin
                w_ok = 1'b0;
            end
        endcase
        imm     = w_ok ? w_field : '0;
        imm_err = !w_ok;
    end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_encoder : two-stage valid/ready pipeline around imm_pack, error counter
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_encoder
    import imm_encoder_pkg::*;
(
    input wire logic     clk,
    input wire logic     rst_n,
    imm_encoder_if.slave bus
);

    logic                   r_s1_valid;
    logic [VAL_W-1:0]       r_s1_val;
    logic [2:0]             r_s1_sel;
    logic                   r_s2_valid;
    logic [IMM_FIELD_W-1:0] r_imm;
    logic [IMM_FIELD_W-1:0] r_imm_mask;
    logic                   r_imm_err;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_s1_ready;
    logic                   w_s2_ready;
    logic                   w_out_xfer;
    logic [IMM_FIELD_W-1:0] w_pk_imm;
    logic [IMM_FIELD_W-1:0] w_pk_mask;
    logic                   w_pk_err;

    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_out_xfer = r_s2_valid && bus.out_ready;

    // Held high while reset is asserted; no word is captured then anyway
    assign bus.in_ready  = w_s1_ready || !rst_n;
    assign bus.out_valid = r_s2_valid;
    assign bus.imm       = r_imm;
    assign bus.imm_mask  = r_imm_mask;
    assign bus.imm_err   = r_imm_err;
    assign bus.err_cnt   = r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_sel   <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_val <= bus.ImmExt;
                r_s1_sel <= bus.ImmSel;
            end
        end
    end

    imm_pack u_imm_pack (
        .val      (r_s1_val),
        .sel      (r_s1_sel),
        .imm      (w_pk_imm),
        .imm_mask (w_pk_mask),
        .imm_err  (w_pk_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_imm      <= '0;
            r_imm_mask <= '0;
            r_imm_err  <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_imm      <= w_pk_imm;
                r_imm_mask <= w_pk_mask;
                r_imm_err  <= w_pk_err;
            end
        end
    end

    // Clear has priority over a coincident errored delivery
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_xfer && r_imm_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm_encoder : directed vector table plus stream, counter and reset sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] val;
        logic [24:0] imm;
        logic [24:0] mask;
        logic        err;
    } vec_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] val;
        logic [24:0] imm;
        logic [24:0] mask;
        logic        err;
        logic        rt;
        logic        lat;
        int          t_in;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t        vecs [16];
    sb_t         sb [$];
    sb_t         cur;
    int          checks = 0;
    int          errors = 0;
    int          tick_no = 0;
    int          pops = 0;
    logic [15:0] exp_cnt = 16'h0;
    logic        ix_last = 1'b0;
    logic        stall_seen = 1'b0;
    logic        stall_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Standard RV32I immediate decode of instr[31:7]
    function automatic logic [31:0] rv_decode(input logic [2:0] sel, input logic [24:0] f);
        logic [31:0] i;
        i = {f, 7'b0};
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'b0};
        endcase
    endfunction

    function automatic logic [31:0] legal_val(input logic [2:0] sel);
        logic [31:0] r;
        r = $urandom();
        case (sel)
            3'd0, 3'd1: return {{20{r[11]}}, r[11:0]};
            3'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       return {{11{r[20]}}, r[20:1], 1'b0};
            default:    return {r[31:12], 12'b0};
        endcase
    endfunction

    task automatic set_in(input vec_t v, input logic lat);
        bus.in_valid = 1'b1;
        bus.ImmSel   = v.sel;
        bus.ImmExt   = v.val;
        cur.sel = v.sel; cur.val = v.val; cur.imm = v.imm; cur.mask = v.mask;
        cur.err = v.err; cur.rt = 1'b0; cur.lat = lat; cur.t_in = 0;
    endtask

    task automatic set_rt(input logic [2:0] sel, input logic [31:0] val);
        bus.in_valid = 1'b1;
        bus.ImmSel   = sel;
        bus.ImmExt   = val;
        cur.sel = sel; cur.val = val; cur.imm = '0; cur.mask = '0;
        cur.err = 1'b0; cur.rt = 1'b1; cur.lat = 1'b0; cur.t_in = 0;
    endtask

    // One clock: sample just before the falling edge, score transfers, advance
    task automatic tick();
        sb_t  e;
        logic ix, ox, e_err;
        #3;
        ix = rst_n && bus.in_valid && bus.in_ready;
        ox = rst_n && bus.out_valid && bus.out_ready;
        if (rst_n && bus.in_valid && !bus.in_ready) stall_seen = 1'b1;
        if (stall_chk && rst_n && !bus.in_ready)
            chk("stall_both_full", {31'b0, bus.out_valid && !bus.out_ready}, 32'd1);
        e_err = 1'b0;
        if (ox) begin
            pops++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got word imm=%h required none in flight", bus.imm);
            end else begin
                e = sb.pop_front();
                e_err = e.err;
                if (e.rt) begin
                    chk("rt_err", {31'b0, bus.imm_err}, 32'd0);
                    chk("rt_value", rv_decode(e.sel, bus.imm), e.val);
                end else begin
                    chk("imm", {7'b0, bus.imm}, {7'b0, e.imm});
                    chk("imm_mask", {7'b0, bus.imm_mask}, {7'b0, e.mask});
                    chk("imm_err", {31'b0, bus.imm_err}, {31'b0, e.err});
                    if (e.lat) chk("latency", 32'(tick_no - e.t_in), 32'd2);
                end
            end
        end
        if (!rst_n || bus.err_clr) exp_cnt = 16'h0;
        else if (ox && e_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
        if (ix) begin
            e = cur;
            e.t_in = tick_no;
            sb.push_back(e);
        end
        ix_last = ix;
        @(posedge clk);
        #1;
        tick_no++;
        chk("err_cnt", {16'b0, bus.err_cnt}, {16'b0, exp_cnt});
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (sb.size() > 0 && n < max) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words outstanding required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, cyc, sent, n;
        logic [2:0] s;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 25'h1FFE000, 25'h1FFE000, 1'b0};
        vecs[1]  = '{3'd1, 32'h000007FF, 25'h0FC001F, 25'h1FC001F, 1'b0};
        vecs[2]  = '{3'd2, 32'h00000800, 25'h0000001, 25'h1FC001F, 1'b0};
        vecs[3]  = '{3'd2, 32'h00000003, 25'h0000000, 25'h1FC001F, 1'b1};
        vecs[4]  = '{3'd3, 32'h00100000, 25'h0000000, 25'h1FFFFE0, 1'b1};
        vecs[5]  = '{3'd4, 32'h12345000, 25'h02468A0, 25'h1FFFFE0, 1'b0};
        vecs[6]  = '{3'd0, 32'h00000800, 25'h0000000, 25'h1FFE000, 1'b1};
        vecs[7]  = '{3'd0, 32'hFFFFF800, 25'h1000000, 25'h1FFE000, 1'b0};
        vecs[8]  = '{3'd3, 32'hFFF00000, 25'h1000000, 25'h1FFFFE0, 1'b0};
        vecs[9]  = '{3'd3, 32'h000FFFFE, 25'h0FFFFE0, 25'h1FFFFE0, 1'b0};
        vecs[10] = '{3'd4, 32'h00000001, 25'h0000000, 25'h1FFFFE0, 1'b1};
        vecs[11] = '{3'd5, 32'h00000000, 25'h0000000, 25'h0000000, 1'b1};
        vecs[12] = '{3'd7, 32'h00001000, 25'h0000000, 25'h0000000, 1'b1};
        vecs[13] = '{3'd1, 32'hFFFFF800, 25'h1000000, 25'h1FC001F, 1'b0};
        vecs[14] = '{3'd2, 32'hFFFFF000, 25'h1000000, 25'h1FC001F, 1'b0};
        vecs[15] = '{3'd2, 32'h00001000, 25'h0000000, 25'h1FC001F, 1'b1};

        bus.in_valid  = 1'b0;
        bus.ImmExt    = '0;
        bus.ImmSel    = '0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        tick();
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_imm", {7'b0, bus.imm}, 32'd0);
        chk("reset_imm_mask", {7'b0, bus.imm_mask}, 32'd0);
        chk("reset_imm_err", {31'b0, bus.imm_err}, 32'd0);
        rst_n = 1'b1;

        // Directed table, one word at a time
        for (int k = 0; k < 16; k++) begin
            set_in(vecs[k], 1'b1);
            tick();
            chk("in_accept", {31'b0, ix_last}, 32'd1);
            bus.in_valid = 1'b0;
            drain(10);
        end

        // 8-word stream with backpressure in cycles 3-6
        idx = 0; cyc = 0; pops = 0; stall_seen = 1'b0; stall_chk = 1'b1;
        while ((idx < 8 || sb.size() > 0) && cyc < 60) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 8) set_in(vecs[idx], 1'b0);
            else bus.in_valid = 1'b0;
            tick();
            if (ix_last) idx++;
            cyc++;
        end
        stall_chk = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_accepted", 32'(idx), 32'd8);
        chk("stream_delivered", 32'(pops), 32'd8);
        chk("stream_stall_seen", {31'b0, stall_seen}, 32'd1);
        drain(5);

        // err_clr coincident with an errored delivery
        bus.out_ready = 1'b0;
        set_in(vecs[3], 1'b0);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("clr_word_ready", {31'b0, bus.out_valid}, 32'd1);
        bus.err_clr   = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_wins", {16'b0, bus.err_cnt}, 32'd0);
        drain(5);

        // Drive the counter into saturation
        sent = 0; cyc = 0;
        while (sent < 65538 && cyc < 70000) begin
            set_in(vecs[11], 1'b0);
            tick();
            if (ix_last) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        drain(10);
        chk("sat_value", {16'b0, bus.err_cnt}, 32'h0000FFFF);

        // Reset while both stages hold words
        bus.out_ready = 1'b0;
        set_in(vecs[11], 1'b0);
        tick();
        set_in(vecs[12], 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("both_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        sb.delete();
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_err_cnt", {16'b0, bus.err_cnt}, 32'd0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("postrst_out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Round trip of random legal values in every format
        sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 12000) begin
            s = 3'($urandom_range(0, 4));
            set_rt(s, legal_val(s));
            tick();
            if (ix_last) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rt_sent", 32'(sent), 32'd10000);
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
